// File: rtl/fb_blank_write_arbiter.sv
// Framebuffer port arbiter: display owns the RAM during active video, and the writer gets
// bounded bursts in blanking. RAM outputs are registered, and display read data is valid 2 clks on.
// The writer is stalled by withholding wr_ack, and at most one word is accepted every other clk_en.
module fb_blank_write_arbiter #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 8,
    parameter int H_LAST    = 800,
    parameter int GUARD     = 8,
    parameter int MAX_BURST = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_en,
    input  logic [10:0]       h_count,
    input  logic              hblank,
    input  logic              vblank,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              wr_grant,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {DISP, WRITE} state_t;

    localparam logic [10:0] H_CLOSE   = 11'(H_LAST + 1 - GUARD);
    localparam logic [7:0]  BURST_MAX = 8'(MAX_BURST);

    state_t              state, state_nxt;
    logic [7:0]          burst, burst_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   wdata_nxt;
    logic                we_nxt, ack_nxt;
    logic                rd_pend;
    logic                win_open, can_write;

    // Window closes GUARD h_count values before line end so the display gets the RAM back in time.
    assign win_open   = vblank | (hblank & (h_count < H_CLOSE));
    // !wr_ack: the writer has not yet presented its next word in the ack cycle.
    assign can_write  = win_open & wr_req & ~wr_ack & (burst < BURST_MAX);
    assign wr_grant   = (state == WRITE);
    assign disp_rdata = mem_rdata;

    always_comb begin
        state_nxt = state;
        burst_nxt = burst;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        we_nxt    = 1'b0;
        ack_nxt   = 1'b0;
        if (clk_en) begin
            if (!win_open) begin
                burst_nxt = '0;
            end
            case (state)
                DISP: begin
                    addr_nxt = disp_addr;
                    if (can_write) begin
                        state_nxt = WRITE;
                    end
                end
                WRITE: begin
                    if (can_write) begin
                        addr_nxt  = wr_addr;
                        wdata_nxt = wr_data;
                        we_nxt    = 1'b1;
                        ack_nxt   = 1'b1;
                        burst_nxt = burst + 8'd1;
                    end else if (!win_open || !wr_req || burst == BURST_MAX) begin
                        state_nxt = DISP;
                        addr_nxt  = disp_addr;
                    end
                end
                default: state_nxt = DISP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= DISP;
            burst       <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_we      <= 1'b0;
            wr_ack      <= 1'b0;
            rd_pend     <= 1'b0;
            disp_rvalid <= 1'b0;
        end else begin
            state       <= state_nxt;
            burst       <= burst_nxt;
            mem_addr    <= addr_nxt;
            mem_wdata   <= wdata_nxt;
            mem_we      <= we_nxt;
            wr_ack      <= ack_nxt;
            // Address is registered this clk, and the RAM returns the data on the next one.
            rd_pend     <= clk_en & (state == DISP);
            disp_rvalid <= rd_pend;
        end
    end

endmodule

// File: tb/tb_fb_blank_write_arbiter.sv
// Directed bench for fb_blank_write_arbiter: each task drives one scenario and checks inline.
module tb_fb_blank_write_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk_en;
    logic [10:0] h_count;
    logic        hblank, vblank;
    logic [18:0] disp_addr;
    logic        disp_rvalid;
    logic [7:0]  disp_rdata;
    logic        wr_req;
    logic [18:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack, wr_grant;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int total = 0;
    int bad   = 0;

    fb_blank_write_arbiter dut (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .h_count(h_count),
        .hblank(hblank), .vblank(vblank), .disp_addr(disp_addr),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata), .wr_req(wr_req),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_grant(wr_grant),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Writer presents its next word in the cycle it sees wr_ack.
    task automatic adv();
        wr_addr = wr_addr + 19'd1;
        wr_data = wr_data + 8'd1;
    endtask

    // One full line h=0..800 with hblank from hb_start and wr_req from req_from.
    task automatic run_line(input int hb_start, input int req_from,
                            output int acks, output int first_h, output int last_h, output int b2b);
        int prev;
        acks = 0; first_h = -1; last_h = -1; b2b = 0; prev = 0;
        for (int h = 0; h <= 800; h++) begin
            h_count   = 11'(h);
            hblank    = (h >= hb_start);
            wr_req    = (h >= req_from);
            disp_addr = 19'(h);
            tick();
            if (mem_we) begin
                acks++;
                if (first_h < 0) first_h = h;
                last_h = h;
                if (prev != 0) b2b++;
            end
            prev = int'(mem_we);
            if (wr_ack) adv();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; clk_en = 1'b0; h_count = '0; hblank = 1'b0; vblank = 1'b0;
        disp_addr = '0; wr_req = 1'b0; wr_addr = 19'h100; wr_data = 8'h10; mem_rdata = 8'h5A;
        repeat (3) tick();
        total++; if (mem_addr !== 19'd0) begin bad++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
        total++; if (mem_wdata !== 8'd0) begin bad++; $display("FAIL reset_mem_wdata: got %0h want 0", mem_wdata); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL reset_wr_ack: got %b want 0", wr_ack); end
        total++; if (wr_grant !== 1'b0) begin bad++; $display("FAIL reset_wr_grant: got %b want 0", wr_grant); end
        total++; if (disp_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b want 0", disp_rvalid); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_active_video();
        logic [18:0] a;
        clk_en = 1'b1; hblank = 1'b0; vblank = 1'b0; h_count = 11'd100; wr_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = 19'(1000 + 3 * i);
            disp_addr = a;
            tick();
            total++; if (wr_ack !== 1'b0 || wr_grant !== 1'b0) begin bad++; $display("FAIL active_no_write: i=%0d ack=%b grant=%b want 0 0", i, wr_ack, wr_grant); end
            total++; if (mem_addr !== a) begin bad++; $display("FAIL active_mem_addr: i=%0d got %0d want %0d", i, mem_addr, a); end
            total++; if (disp_rvalid !== (i >= 1)) begin bad++; $display("FAIL active_rvalid: i=%0d got %b want %b", i, disp_rvalid, (i >= 1)); end
        end
        total++; if (disp_rdata !== 8'h5A) begin bad++; $display("FAIL active_rdata: got %0h want 5a", disp_rdata); end
    endtask

    task automatic test_hblank_line();
        int acks, first_h, last_h, b2b, prev, late;
        acks = 0; first_h = -1; last_h = -1; b2b = 0; prev = 0; late = 0;
        vblank = 1'b0; wr_req = 1'b1;
        for (int h = 0; h <= 800; h++) begin
            h_count = 11'(h); hblank = (h >= 600); disp_addr = 19'(h);
            tick();
            if (mem_we) begin
                acks++;
                if (first_h < 0) first_h = h;
                last_h = h;
                if (prev != 0) b2b++;
                if (h >= 793) late++;
                total++; if (mem_addr !== wr_addr || mem_wdata !== wr_data || wr_ack !== 1'b1) begin
                    bad++; $display("FAIL burst_word: h=%0d addr=%0h data=%0h ack=%b want %0h %0h 1", h, mem_addr, mem_wdata, wr_ack, wr_addr, wr_data);
                end
            end
            prev = int'(mem_we);
            if (wr_ack) adv();
        end
        total++; if (acks != 64) begin bad++; $display("FAIL burst_count: got %0d want 64", acks); end
        total++; if (first_h != 601 || last_h != 727) begin bad++; $display("FAIL burst_span: got %0d..%0d want 601..727", first_h, last_h); end
        total++; if (b2b != 0 || late != 0) begin bad++; $display("FAIL burst_spacing: b2b=%0d late=%0d want 0 0", b2b, late); end
        total++; if (wr_grant !== 1'b0) begin bad++; $display("FAIL line_end_disp: got %b want 0", wr_grant); end
        // Short window: writes decided at 702..792, the last open h_count.
        run_line(701, 0, acks, first_h, last_h, b2b);
        total++; if (acks != 46 || first_h != 702 || last_h != 792) begin bad++; $display("FAIL guard_line: acks=%0d span=%0d..%0d want 46 702..792", acks, first_h, last_h); end
        total++; if (b2b != 0) begin bad++; $display("FAIL guard_spacing: got %0d want 0", b2b); end
    endtask

    task automatic test_late_req();
        int acks, first_h, last_h, b2b;
        run_line(600, 792, acks, first_h, last_h, b2b);
        total++; if (acks != 0) begin bad++; $display("FAIL late_req_none: got %0d want 0", acks); end
        total++; if (wr_grant !== 1'b0) begin bad++; $display("FAIL late_req_grant: got %b want 0", wr_grant); end
        run_line(600, 0, acks, first_h, last_h, b2b);
        total++; if (first_h != 601 || acks != 64) begin bad++; $display("FAIL late_req_next: first=%0d acks=%0d want 601 64", first_h, acks); end
    endtask

    task automatic test_vblank();
        int acks, grant_late, first_h, last_h, b2b;
        acks = 0; grant_late = 0;
        vblank = 1'b1; hblank = 1'b0; h_count = 11'd100; wr_req = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (mem_we) acks++;
            if (i >= 200 && wr_grant) grant_late++;
            if (wr_ack) adv();
        end
        total++; if (acks != 64) begin bad++; $display("FAIL vblank_acks: got %0d want 64", acks); end
        total++; if (grant_late != 0) begin bad++; $display("FAIL vblank_grant_after: got %0d want 0", grant_late); end
        vblank = 1'b0;
        acks = 0; grant_late = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_we) acks++;
            if (wr_grant) grant_late++;
        end
        total++; if (acks != 0 || grant_late != 0) begin bad++; $display("FAIL vblank_fall_active: acks=%0d grant=%0d want 0 0", acks, grant_late); end
        run_line(600, 0, acks, first_h, last_h, b2b);
        total++; if (first_h != 601 || acks != 64) begin bad++; $display("FAIL vblank_next_hblank: first=%0d acks=%0d want 601 64", first_h, acks); end
    endtask

    task automatic test_reset_mid_burst();
        int n, acks;
        vblank = 1'b1; hblank = 1'b0; h_count = 11'd100; wr_req = 1'b1; n = 0;
        do begin tick(); n++; end while (!mem_we && n < 20);
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL rst_setup: no write within %0d clks", n); end
        reset_n = 1'b0;
        #1;
        total++; if (mem_we !== 1'b0 || wr_ack !== 1'b0 || wr_grant !== 1'b0) begin
            bad++; $display("FAIL rst_async_drop: we=%b ack=%b grant=%b want 0 0 0", mem_we, wr_ack, wr_grant);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        #1;
        total++; if (wr_grant !== 1'b0) begin bad++; $display("FAIL rst_state_disp: got %b want 0", wr_grant); end
        acks = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (mem_we) acks++;
            if (wr_ack) adv();
        end
        total++; if (acks != 64) begin bad++; $display("FAIL rst_burst_cleared: got %0d want 64", acks); end
    endtask

    task automatic test_clk_en_stall();
        int acks, n, stall_bad;
        logic [18:0] saved;
        vblank = 1'b0; h_count = 11'd100; wr_req = 1'b1;
        repeat (2) tick();
        vblank = 1'b1; acks = 0; n = 0;
        while (acks < 5 && n < 50) begin
            tick(); n++;
            if (mem_we) acks++;
            if (wr_ack) adv();
        end
        total++; if (acks != 5) begin bad++; $display("FAIL stall_setup: got %0d acks want 5", acks); end
        saved = mem_addr;
        clk_en = 1'b0; stall_bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wr_ack || mem_we || mem_addr !== saved || !wr_grant) stall_bad++;
        end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL stall_frozen: got %0d bad clks want 0", stall_bad); end
        clk_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (mem_we) acks++;
            if (wr_ack) adv();
        end
        total++; if (acks != 64) begin bad++; $display("FAIL stall_resume_total: got %0d want 64", acks); end
    endtask

    initial begin
        test_reset();
        test_active_video();
        test_hblank_line();
        test_late_req();
        test_vblank();
        test_reset_mid_burst();
        test_clk_en_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
